// File: rtl/seq_pkg.sv
// Shared opcode and state encodings for the instruction sequencer.
package seq_pkg;

   typedef enum logic [1:0] {OP_REG, OP_STORE, OP_JUMP, OP_HALT} op_t;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

endpackage

// File: rtl/instr_sequencer.sv
// Program counter / control sequencer: steps instruction_A, decodes the
// returned word with zero latency and issues one write strobe per instruction.
module instr_sequencer
   import seq_pkg::*;
#(
   parameter int ADDR_W = 3,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stall,
   input  logic [ADDR_W+1:0] instr_word,
   output logic [ADDR_W-1:0] instruction_A,
   output logic              RegWrite,
   output logic              MemWrite,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  retired
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   op_t               op;
   logic [ADDR_W-1:0] target;
   logic              exec;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   assign op     = op_t'(instr_word[ADDR_W+1:ADDR_W]);
   assign target = instr_word[ADDR_W-1:0];
   // start takes priority: a restart cycle never executes the current word
   assign exec   = (state_q == S_RUN) && !stall && !start;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      if (start) begin
         state_d = S_RUN;
         pc_d    = '0;
         cnt_d   = '0;
      end else if (exec) begin
         cnt_d = sat_inc(cnt_q);
         unique case (op)
            OP_REG, OP_STORE: pc_d = pc_q + 1'b1;
            OP_JUMP:          pc_d = target;
            OP_HALT:          state_d = S_HALT;
            default:          pc_d = pc_q;
         endcase
      end
   end

   assign RegWrite      = exec && (op == OP_REG);
   assign MemWrite      = exec && (op == OP_STORE);
   assign busy          = (state_q == S_RUN);
   assign done          = (state_q == S_HALT);
   assign instruction_A = pc_q;
   assign retired       = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench: directed scenarios plus randomized programs compared
// against a cycle-level behavioural model of the sequencer.
module tb_instr_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       stall = 1'b0;
   logic [4:0] prog [8];
   logic [4:0] iw, iw3;
   logic [2:0] pc_a, pc3;
   logic       rw, mw, rw3, mw3, busy, done, busy3, done3;
   logic [7:0] ret;
   logic [2:0] ret3;

   int n_checks = 0;
   int n_pass   = 0;
   int m_mode, m_pc, m_ret, m_ret3;   // mode: 0 idle, 1 run, 2 halted

   always #5 clk = ~clk;

   assign iw  = prog[pc_a];
   assign iw3 = prog[pc3];

   instr_sequencer #(.ADDR_W(3), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .stall(stall), .instr_word(iw),
      .instruction_A(pc_a), .RegWrite(rw), .MemWrite(mw), .busy(busy),
      .done(done), .retired(ret));

   instr_sequencer #(.ADDR_W(3), .CNT_W(3)) dut3 (
      .clk(clk), .rst(rst), .start(start), .stall(stall), .instr_word(iw3),
      .instruction_A(pc3), .RegWrite(rw3), .MemWrite(mw3), .busy(busy3),
      .done(done3), .retired(ret3));

   task automatic model_reset();
      m_mode = 0; m_pc = 0; m_ret = 0; m_ret3 = 0;
   endtask

   function automatic logic [17:0] expv();
      int  op;
      logic ex;
      op = int'(prog[m_pc][4:3]);
      ex = (m_mode == 1) && !stall && !start;
      return {3'(m_pc), ex && op == 0, ex && op == 1, m_mode == 1, m_mode == 2,
              8'(m_ret), 3'(m_ret3)};
   endfunction

   function automatic logic [17:0] actv();
      return {pc_a, rw, mw, busy, done, ret, ret3};
   endfunction

   // drive inputs just after the falling edge, let combinational outputs settle
   task automatic drive(input logic s, input logic st);
      start = s; stall = st; #1;
   endtask

   // advance the model by one clock, following the architectural rules
   task automatic tick();
      int op;
      op = int'(prog[m_pc][4:3]);
      if (start) begin
         m_mode = 1; m_pc = 0; m_ret = 0; m_ret3 = 0;
      end else if (m_mode == 1 && !stall) begin
         m_ret  = (m_ret  < 255) ? m_ret + 1  : 255;
         m_ret3 = (m_ret3 < 7)   ? m_ret3 + 1 : 7;
         if (op == 0 || op == 1) m_pc = (m_pc + 1) % 8;
         else if (op == 2)       m_pc = int'(prog[m_pc][2:0]);
         else                    m_mode = 2;
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; stall = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; model_reset();
      for (int i = 0; i < 2; i++) begin
         drive(0, 0);
         n_checks++;
         if (actv() !== expv()) $display("FAIL reset_hold cyc%0d got %h exp %h", i, actv(), expv());
         else n_pass++;
         @(posedge clk); @(negedge clk);
      end
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(0, (i == 2));
         n_checks++;
         if (actv() !== 18'h0) $display("FAIL reset_idle cyc%0d got %h exp %h", i, actv(), 18'h0);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_straight();
      for (int i = 0; i < 8; i++) prog[i] = 5'b11_000;
      prog[0] = 5'b00_000; prog[1] = 5'b01_000; prog[2] = 5'b00_000; prog[3] = 5'b11_000;
      drive(1, 0); tick();
      for (int i = 0; i < 6; i++) begin
         drive(0, 0);
         n_checks++;
         if (actv() !== expv()) $display("FAIL straight cyc%0d got %h exp %h", i, actv(), expv());
         else n_pass++;
         tick();
      end
      n_checks++;
      if (done !== 1'b1 || ret !== 8'd4 || pc_a !== 3'd3)
         $display("FAIL straight_end got done=%b ret=%0d pc=%0d exp done=1 ret=4 pc=3", done, ret, pc_a);
      else n_pass++;
   endtask

   task automatic test_jump_wrap();
      int seq [7];
      seq = '{0, 1, 2, 6, 7, 0, 1};
      for (int i = 0; i < 8; i++) prog[i] = 5'b00_000;
      prog[2] = 5'b10_110;
      drive(1, 0); tick();
      for (int i = 0; i < 7; i++) begin
         drive(0, 0);
         n_checks++;
         if (actv() !== expv() || pc_a !== 3'(seq[i]) || rw !== (seq[i] != 2))
            $display("FAIL jump_wrap cyc%0d got %h pc=%0d exp %h pc=%0d", i, actv(), pc_a, expv(), seq[i]);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 8; i++) prog[i] = 5'b00_000;
      prog[1] = 5'b01_000;
      drive(1, 0); tick();
      drive(0, 0); tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, 1);
         n_checks++;
         if (actv() !== expv() || pc_a !== 3'd1 || mw !== 1'b0 || ret !== 8'd1)
            $display("FAIL stall_hold cyc%0d got %h exp %h", i, actv(), expv());
         else n_pass++;
         tick();
      end
      drive(0, 0);
      n_checks++;
      if (actv() !== expv() || mw !== 1'b1) $display("FAIL stall_release got %h exp %h", actv(), expv());
      else n_pass++;
      tick();
      drive(0, 0);
      n_checks++;
      if (actv() !== expv() || mw !== 1'b0 || ret !== 8'd2)
         $display("FAIL stall_after got %h exp %h", actv(), expv());
      else n_pass++;
      tick();
   endtask

   task automatic test_restart_reset();
      for (int i = 0; i < 8; i++) prog[i] = 5'b00_000;
      drive(1, 0); tick();
      for (int i = 0; i < 5; i++) begin drive(0, 0); tick(); end
      drive(1, 1);
      n_checks++;
      if (actv() !== expv() || pc_a !== 3'd5 || rw !== 1'b0)
         $display("FAIL restart_cycle got %h exp %h", actv(), expv());
      else n_pass++;
      tick();
      drive(0, 0);
      n_checks++;
      if (actv() !== expv() || pc_a !== 3'd0 || ret !== 8'd0 || busy !== 1'b1)
         $display("FAIL restart_after got %h exp %h", actv(), expv());
      else n_pass++;
      tick();
      drive(0, 0);
      rst = 1'b0; model_reset(); #1;
      n_checks++;
      if (actv() !== 18'h0) $display("FAIL reset_midrun got %h exp %h", actv(), 18'h0);
      else n_pass++;
      @(posedge clk); @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 8; i++) prog[i] = 5'b00_000;
      prog[0] = 5'b10_000;
      drive(1, 0); tick();
      for (int i = 0; i < 10; i++) begin
         drive(0, 0);
         n_checks++;
         if (actv() !== expv()) $display("FAIL saturation cyc%0d got %h exp %h", i, actv(), expv());
         else n_pass++;
         tick();
      end
      drive(0, 0);
      n_checks++;
      if (ret3 !== 3'd7 || ret !== 8'd10 || pc_a !== 3'd0)
         $display("FAIL saturation_end got ret3=%0d ret=%0d exp ret3=7 ret=10", ret3, ret);
      else n_pass++;
      tick();
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 8; i++) prog[i] = 5'($urandom_range(0, 31));
         drive(1, 0); tick();
         for (int i = 0; i < 80; i++) begin
            drive($urandom_range(0, 99) < 6, $urandom_range(0, 99) < 25);
            n_checks++;
            if (actv() !== expv()) $display("FAIL random r%0d cyc%0d got %h exp %h", r, i, actv(), expv());
            else n_pass++;
            tick();
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) prog[i] = 5'b00_000;
      @(negedge clk);
      test_reset();
      test_straight();
      test_jump_wrap();
      test_stall();
      test_restart_reset();
      test_saturation();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
